vga_grid_capture: RTL and testbench

//   Receive end of the VGA display link: watches VGA_hSync/VGA_vSync/VGA_R/G/B from the display

---
 rtl/vga_grid_capture.sv | 236 +++++++++++++++++++++++
 tb/tb_vga_grid_capture.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_grid_capture.sv
// vga_grid_capture: receive side of the VGA link. Tracks hSync/vSync timing,
// locks after two clean frames and rebuilds the cell grid by sampling the
// centre pixel of every cell. Each complete, well-timed frame is published to
// data with a one-clock frame_valid pulse.
module vga_grid_capture #(
    parameter int CLK_PER_PIX = 2,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int CELL        = 40
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic                                         hSync,
    input  logic                                         vSync,
    input  logic [3:0]                                   r,
    input  logic [3:0]                                   g,
    input  logic [3:0]                                   b,
    output logic [(H_ACTIVE/CELL)*(V_ACTIVE/CELL)-1:0]   data,
    output logic                                         frame_valid,
    output logic                                         locked,
    output logic                                         timing_err
);

    localparam int COLS    = H_ACTIVE / CELL;
    localparam int ROWS    = V_ACTIVE / CELL;
    localparam int NB      = COLS * ROWS;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_PER   = H_TOTAL * CLK_PER_PIX;
    localparam int DW      = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;
    localparam int HW      = $clog2(H_PER + 2);    // headroom so an overdue hSync is visible
    localparam int PW      = $clog2(H_TOTAL + 1);
    localparam int LW      = $clog2(V_TOTAL + 2);  // headroom so an overdue vSync is visible
    localparam int SW      = $clog2(NB + 1);
    localparam int IW      = $clog2(NB);

    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_PER_PIX - 1);
    localparam logic [HW-1:0] H_PER_C = HW'(H_PER);
    localparam logic [LW-1:0] V_TOT_C = LW'(V_TOTAL);
    localparam logic [SW-1:0] NB_C    = SW'(NB);

    typedef enum logic [1:0] {SEARCH, MEASURE, CAPTURE} state_t;

    // registered input copies and their one-clock-delayed versions for edge detection
    logic          hs_q, vs_q, hs_p_q, vs_p_q;
    logic [11:0]   rgb_q;
    logic          hs_fall, hs_rise, vs_fall, vs_rise, lit;

    // timing counters
    logic [DW-1:0] div_q, div_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [LW-1:0] line_q, line_d;
    logic [LW-1:0] vl_q, vl_d, vl_inc;
    logic          h_seen_q, h_seen_d, v_seen_q, v_seen_d;
    logic          h_err, v_err, per_err;

    // sample position
    logic [31:0]   px, ly, xo, yo;
    logic          samp;
    logic [IW-1:0] idx;

    // FSM and capture state
    state_t        state_q, state_d;
    logic          meas_bad_q, meas_bad_d;
    logic [SW-1:0] samp_cnt_q, samp_cnt_d;
    logic [NB-1:0] shadow_q, shadow_d;
    logic [NB-1:0] data_q, data_d;
    logic          fv_q, fv_d;
    logic          terr_q, terr_d;

    assign hs_fall = hs_p_q & ~hs_q;
    assign hs_rise = ~hs_p_q & hs_q;
    assign vs_fall = vs_p_q & ~vs_q;
    assign vs_rise = ~vs_p_q & vs_q;
    assign lit     = |rgb_q;

    assign data        = data_q;
    assign frame_valid = fv_q;
    assign locked      = (state_q == CAPTURE);
    assign timing_err  = terr_q;

    // input register stage; syncs idle high so reset never creates a false edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            hs_p_q <= 1'b1;
            vs_p_q <= 1'b1;
            rgb_q  <= '0;
        end else begin
            hs_q   <= hSync;
            vs_q   <= vSync;
            hs_p_q <= hs_q;
            vs_p_q <= vs_q;
            rgb_q  <= {r, g, b};
        end
    end

    // pixel/line/period counters and period checks; hSync is applied before vSync
    always_comb begin
        div_d    = div_q;
        pix_d    = pix_q;
        hcnt_d   = (hcnt_q == '1) ? hcnt_q : hcnt_q + HW'(1);
        h_seen_d = h_seen_q | hs_fall;
        line_d   = line_q;
        v_seen_d = v_seen_q | vs_fall;

        if (hs_rise) begin
            div_d = '0;
            pix_d = '0;
        end else if (div_q == DIV_MAX) begin
            div_d = '0;
            if (pix_q != '1) pix_d = pix_q + PW'(1);
        end else begin
            div_d = div_q + DW'(1);
        end

        if (hs_fall) hcnt_d = HW'(1);

        if (vs_rise)                       line_d = '0;
        else if (hs_rise && line_q != '1)  line_d = line_q + LW'(1);

        vl_inc = (hs_rise && vl_q != '1) ? vl_q + LW'(1) : vl_q;
        vl_d   = vs_fall ? '0 : vl_inc;

        h_err   = h_seen_q && ((hs_fall && hcnt_q != H_PER_C) || hcnt_q > H_PER_C);
        v_err   = v_seen_q && ((vs_fall && vl_inc != V_TOT_C) || vl_q > V_TOT_C);
        per_err = h_err | v_err;
    end

    // cell-centre detection: one sample per pixel, on the first clock of the pixel
    always_comb begin
        px   = 32'(pix_q);
        ly   = 32'(line_q);
        xo   = px - H_BP;
        yo   = ly - V_BP;
        samp = (div_q == '0) &&
               (px >= H_BP) && (px < H_BP + H_ACTIVE) &&
               (ly >= V_BP) && (ly < V_BP + V_ACTIVE) &&
               (xo % CELL == CELL / 2) && (yo % CELL == CELL / 2);
        idx  = IW'((yo / CELL) * COLS + xo / CELL);
    end

    // lock FSM, shadow capture and publish
    always_comb begin
        state_d    = state_q;
        meas_bad_d = meas_bad_q;
        samp_cnt_d = samp_cnt_q;
        shadow_d   = shadow_q;
        data_d     = data_q;
        fv_d       = 1'b0;
        terr_d     = terr_q;

        case (state_q)
            SEARCH: begin
                if (vs_fall) begin
                    state_d    = MEASURE;
                    meas_bad_d = 1'b0;
                end
            end
            MEASURE: begin
                if (vs_fall) begin
                    // a failed measurement frame simply restarts at this edge
                    meas_bad_d = 1'b0;
                    if (!meas_bad_q && !per_err) begin
                        state_d    = CAPTURE;
                        samp_cnt_d = '0;
                    end
                end else if (per_err) begin
                    meas_bad_d = 1'b1;
                end
            end
            CAPTURE: begin
                if (per_err) begin
                    state_d    = SEARCH;
                    terr_d     = 1'b1;
                    samp_cnt_d = '0;
                end else if (vs_fall) begin
                    // only a frame that delivered every cell sample is published
                    if (samp_cnt_q == NB_C) begin
                        data_d = shadow_q;
                        fv_d   = 1'b1;
                    end
                    samp_cnt_d = '0;
                end else if (samp) begin
                    shadow_d[idx] = lit;
                    if (samp_cnt_q != NB_C) samp_cnt_d = samp_cnt_q + SW'(1);
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            pix_q      <= '0;
            hcnt_q     <= '0;
            h_seen_q   <= 1'b0;
            line_q     <= '0;
            vl_q       <= '0;
            v_seen_q   <= 1'b0;
            state_q    <= SEARCH;
            meas_bad_q <= 1'b0;
            samp_cnt_q <= '0;
            shadow_q   <= '0;
            data_q     <= '0;
            fv_q       <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            div_q      <= div_d;
            pix_q      <= pix_d;
            hcnt_q     <= hcnt_d;
            h_seen_q   <= h_seen_d;
            line_q     <= line_d;
            vl_q       <= vl_d;
            v_seen_q   <= v_seen_d;
            state_q    <= state_d;
            meas_bad_q <= meas_bad_d;
            samp_cnt_q <= samp_cnt_d;
            shadow_q   <= shadow_d;
            data_q     <= data_d;
            fv_q       <= fv_d;
            terr_q     <= terr_d;
        end
    end

endmodule

// File: tb/tb_vga_grid_capture.sv
// Bench for vga_grid_capture. Uses a scaled-down raster (2-pixel cells, 32x24
// active) so the grid is still 16x12 but each frame is only a few thousand
// clocks. Lines are sent as back porch, active, front porch, sync; frames as
// back porch, active, front porch, sync, so a frame ends with its vSync fall.
module tb_vga_grid_capture;

    localparam int CPP   = 2;
    localparam int H_ACT = 32, H_FP = 2, H_SY = 3, H_BP = 3;
    localparam int V_ACT = 24, V_FP = 1, V_SY = 2, V_BP = 2;
    localparam int CELL  = 2;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         hSync = 1'b1, vSync = 1'b1;
    logic [3:0]   r = '0, g = '0, b = '0;
    logic [191:0] data;
    logic         frame_valid, locked, timing_err;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, vs_fall_cyc = 0, fv_cnt = 0;
    logic fv_prev = 1'b0;
    logic [191:0] exp_two, exp_chk;

    vga_grid_capture #(
        .CLK_PER_PIX(CPP), .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP), .CELL(CELL)
    ) dut (
        .clock(clock), .reset(reset), .hSync(hSync), .vSync(vSync),
        .r(r), .g(g), .b(b), .data(data), .frame_valid(frame_valid),
        .locked(locked), .timing_err(timing_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // every publish: exactly one clock wide, two clocks after the vSync fall is driven
    always @(negedge clock) begin
        if (!reset) begin
            if (frame_valid) begin
                fv_cnt++;
                chk("fv_latency", 192'(cyc - vs_fall_cyc), 192'd2);
                chk("fv_width", {191'd0, fv_prev}, 192'd0);
            end
            fv_prev = frame_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] color(input int pat, input int x, input int y);
        int col, row;
        col = x / CELL;
        row = y / CELL;
        color = 12'h000;
        case (pat)
            1: if ((row == 11 && col == 0) || (row == 0 && col == 15)) color = 12'hF00;
            2: if (((row + col) & 1) == 1) color = 12'h010;
            3: if (((row + col) & 1) == 1 || x == 0) color = 12'h010;
            default: color = 12'h000;
        endcase
    endfunction

    task automatic drive(input logic hs, input logic vs, input logic [11:0] c);
        if (vSync && !vs) vs_fall_cyc = cyc;
        hSync = hs;
        vSync = vs;
        {r, g, b} = c;
        repeat (CPP) @(posedge clock);
        #1;
    endtask

    // async reset in the middle of a line; outputs must clear before any clock edge
    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_data", data, 192'd0);
        chk("async_rst_locked", {191'd0, locked}, 192'd0);
        chk("async_rst_terr", {191'd0, timing_err}, 192'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic send_line(input int pat, input int ln, input logic vs, input int extra, input bit do_rst);
        int len;
        logic [11:0] c;
        len = H_TOT + extra;
        for (int p = 0; p < len; p++) begin
            c = 12'h000;
            if (p >= H_BP && p < H_BP + H_ACT && ln >= V_BP && ln < V_BP + V_ACT)
                c = color(pat, p - H_BP, ln - V_BP);
            drive(p < len - H_SY, vs, c);
            if (do_rst && p == 10) mid_reset();
        end
    endtask

    task automatic send_frame(input int pat, input int stretch_ln, input int rst_ln);
        for (int ln = 0; ln < V_TOT; ln++)
            send_line(pat, ln, ln < V_TOT - V_SY, (ln == stretch_ln) ? 1 : 0, ln == rst_ln);
    endtask

    initial begin
        exp_two = '0;
        exp_two[176] = 1'b1;
        exp_two[15]  = 1'b1;
        exp_chk = '0;
        for (int row = 0; row < 12; row++)
            for (int col = 0; col < 16; col++)
                exp_chk[row * 16 + col] = ((row + col) & 1) == 1;

        // reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_data", data, 192'd0);
        chk("rst_fv", {191'd0, frame_valid}, 192'd0);
        chk("rst_locked", {191'd0, locked}, 192'd0);
        chk("rst_terr", {191'd0, timing_err}, 192'd0);
        reset = 1'b0;

        // no syncs at all
        repeat (200) @(posedge clock);
        #1;
        chk("idle_locked", {191'd0, locked}, 192'd0);

        // 1: three black frames
        send_frame(0, -1, -1);
        chk("t1_f1_locked", {191'd0, locked}, 192'd0);
        send_frame(0, -1, -1);
        chk("t1_f2_locked", {191'd0, locked}, 192'd1);
        chk("t1_f2_fvcnt", 192'(fv_cnt), 192'd0);
        send_frame(0, -1, -1);
        chk("t1_f3_fvcnt", 192'(fv_cnt), 192'd1);
        chk("t1_data", data, 192'd0);
        chk("t1_terr", {191'd0, timing_err}, 192'd0);

        // 2: two corner cells lit in red
        send_frame(1, -1, -1);
        chk("t2_fvcnt", 192'(fv_cnt), 192'd2);
        chk("t2_data", data, exp_two);

        // 3: one line stretched by a pixel, then relock
        send_frame(2, 10, -1);
        chk("t3_terr", {191'd0, timing_err}, 192'd1);
        chk("t3_locked", {191'd0, locked}, 192'd0);
        chk("t3_no_fv", 192'(fv_cnt), 192'd2);
        chk("t3_data_kept", data, exp_two);
        send_frame(2, -1, -1);
        send_frame(2, -1, -1);
        chk("t3_relocked", {191'd0, locked}, 192'd1);
        chk("t3_fvcnt", 192'(fv_cnt), 192'd3);
        chk("t3_data", data, exp_chk);
        chk("t3_terr_sticky", {191'd0, timing_err}, 192'd1);

        // 4: checkerboard, then with a lit off-sample column at x=0
        send_frame(2, -1, -1);
        chk("t4_fvcnt", 192'(fv_cnt), 192'd4);
        chk("t4_data", data, exp_chk);
        send_frame(3, -1, -1);
        chk("t4_col_fvcnt", 192'(fv_cnt), 192'd5);
        chk("t4_col_data", data, exp_chk);

        // 5: reset mid-frame, then a fresh lock
        send_frame(2, -1, 5);
        chk("t5_part_locked", {191'd0, locked}, 192'd0);
        chk("t5_part_fvcnt", 192'(fv_cnt), 192'd5);
        send_frame(1, -1, -1);
        chk("t5_locked", {191'd0, locked}, 192'd1);
        chk("t5_fvcnt_a", 192'(fv_cnt), 192'd5);
        send_frame(1, -1, -1);
        chk("t5_fvcnt_b", 192'(fv_cnt), 192'd6);
        chk("t5_data", data, exp_two);

        // 6: vSync stuck high for many lines after a clean reset
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 60; i++) send_line(2, 5, 1'b1, 0, 1'b0);
        chk("t6_locked", {191'd0, locked}, 192'd0);
        chk("t6_fvcnt", 192'(fv_cnt), 192'd6);
        chk("t6_terr", {191'd0, timing_err}, 192'd0);
        chk("t6_data", data, 192'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
